// File: rtl/csa3_cpa_pipe_pkg.sv
// Shared widths for the compressor / carry-propagate datapath, plus the
// segment-boundary helpers used to slice the staggered ripple adder.
package csa3_cpa_pipe_pkg;

  localparam int CSAWIDTH = 27;
  localparam int SEGW     = 10;
  localparam int TAGW     = 8;
  localparam int OW       = CSAWIDTH + 3;
  localparam int NSEG     = (OW + SEGW - 1) / SEGW;

  function automatic int seg_lo(input int k);
    return k * SEGW;
  endfunction

  // The top segment is whatever is left over, so it may be narrower than SEGW.
  function automatic int seg_w(input int k);
    return ((OW - k * SEGW) < SEGW) ? (OW - k * SEGW) : SEGW;
  endfunction

  function automatic bit in_seg(input int k, input int b);
    return (b >= seg_lo(k)) && (b < seg_lo(k) + seg_w(k));
  endfunction

endpackage

// File: rtl/csa3_cpa_pipe_if.sv
// Input and output streams of the carry-propagate stage.
// slave is the pipe's view; master is the view of the surrounding logic.
interface csa3_cpa_pipe_if;
  import csa3_cpa_pipe_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [CSAWIDTH-1:0] in_o0;
  logic [CSAWIDTH-1:0] in_o1;
  logic [CSAWIDTH-1:0] in_o2;
  logic [TAGW-1:0]     in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [OW-1:0]       out_sum;
  logic [TAGW-1:0]     out_tag;

  modport slave (
    input  in_valid, in_o0, in_o1, in_o2, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag
  );

  modport master (
    output in_valid, in_o0, in_o1, in_o2, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag
  );

endinterface

// File: rtl/csa3_cpa_pipe_csa_seg_add.sv
// One segment of the staggered ripple adder: W-bit add with carry-in/out.
module csa_seg_add
  import csa3_cpa_pipe_pkg::*;
#(
  parameter int W = SEGW
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/csa3_cpa_pipe.sv
// Full-adder layer (stage 0) folding three weighted rows into a carry-save
// pair, followed by NSEG staggered ripple segments, one per cycle.
module csa3_cpa_pipe
  import csa3_cpa_pipe_pkg::*;
(
  input logic             ap_clk,
  input logic             ap_rst_n,
  csa3_cpa_pipe_if.slave  s
);

  logic                adv;
  logic [OW-1:0]       r0, r1, r2;
  logic [OW-1:0]       fa_s, fa_c;
  logic [OW-2:0]       maj;

  logic [NSEG:0]       v;
  logic [TAGW-1:0]     tg [0:NSEG];
  logic [OW-1:0]       sm [0:NSEG];
  logic [OW-1:0]       ps [0:NSEG-1];
  logic [OW-1:0]       pc [0:NSEG-1];
  logic                cy [0:NSEG-1];

  logic [OW-1:0]       seg_sum;
  logic                seg_co [1:NSEG-1];
  logic                cout_unused;

  assign adv        = ~v[NSEG] | s.out_ready;
  assign s.in_ready = adv;

  assign r0 = {3'b000, s.in_o0};
  assign r1 = {2'b00, s.in_o1, 1'b0};
  assign r2 = {1'b0, s.in_o2, 2'b00};

  // The top bit of every row is zero, so the majority never reaches bit OW-1
  // and the shifted carry fits in OW bits.
  assign fa_s = r0 ^ r1 ^ r2;
  assign maj  = (r0[OW-2:0] & r1[OW-2:0]) | (r0[OW-2:0] & r2[OW-2:0]) |
                (r1[OW-2:0] & r2[OW-2:0]);
  assign fa_c = {maj, 1'b0};

  for (genvar k = 1; k <= NSEG; k++) begin : g_seg
    localparam int LO = seg_lo(k - 1);
    localparam int W  = seg_w(k - 1);
    logic cout;

    csa_seg_add #(.W(W)) u_add (
      .a    (ps[k-1][LO +: W]),
      .b    (pc[k-1][LO +: W]),
      .cin  (cy[k-1]),
      .sum  (seg_sum[LO +: W]),
      .cout (cout)
    );

    if (k < NSEG) begin : g_mid
      assign seg_co[k] = cout;
    end else begin : g_top
      assign cout_unused = cout;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      v <= '0;
      for (int k = 0; k <= NSEG; k++) begin
        tg[k] <= '0;
        sm[k] <= '0;
      end
      for (int k = 0; k < NSEG; k++) begin
        ps[k] <= '0;
        pc[k] <= '0;
        cy[k] <= 1'b0;
      end
    end else if (adv) begin
      v[0]  <= s.in_valid;
      sm[0] <= '0;
      cy[0] <= 1'b0;
      if (s.in_valid) begin
        ps[0] <= fa_s;
        pc[0] <= fa_c;
        tg[0] <= s.in_tag;
      end
      // Each stage overwrites only its own segment; finished segments ride along.
      for (int k = 1; k <= NSEG; k++) begin
        v[k]  <= v[k-1];
        tg[k] <= tg[k-1];
        for (int b = 0; b < OW; b++)
          sm[k][b] <= in_seg(k - 1, b) ? seg_sum[b] : sm[k-1][b];
      end
      for (int k = 1; k < NSEG; k++) begin
        ps[k] <= ps[k-1];
        pc[k] <= pc[k-1];
        cy[k] <= seg_co[k];
      end
    end
  end

  assign s.out_valid = v[NSEG];
  assign s.out_sum   = sm[NSEG];
  assign s.out_tag   = tg[NSEG];

endmodule

// File: tb/tb_csa3_cpa_pipe.sv
// Self-checking bench for csa3_cpa_pipe: directed corners, random streams
// with backpressure, and reset in the middle of a stream.
module tb_csa3_cpa_pipe;
  import csa3_cpa_pipe_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  csa3_cpa_pipe_if bus();

  csa3_cpa_pipe dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .s        (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [OW-1:0]   sum;
    logic [TAGW-1:0] tag;
  } exp_t;
  exp_t q[$];

  function automatic logic [OW-1:0] ref_sum(input logic [CSAWIDTH-1:0] a,
                                            input logic [CSAWIDTH-1:0] b,
                                            input logic [CSAWIDTH-1:0] c);
    logic [63:0] t;
    t = 64'(a) + 64'(b) * 2 + 64'(c) * 4;
    return t[OW-1:0];
  endfunction

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.in_o0    = '0;
    bus.in_o1    = '0;
    bus.in_o2    = '0;
    bus.in_tag   = '0;
  endtask

  task automatic drive_rand(input logic [TAGW-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_o0    = CSAWIDTH'($urandom);
    bus.in_o1    = CSAWIDTH'($urandom);
    bus.in_o2    = CSAWIDTH'($urandom);
    bus.in_tag   = tag;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    drive_rand(8'hA5);
    bus.out_ready = 1'b0;
    repeat (3) next_cycle();
    drive_idle();
    ap_rst_n = 1'b1;
    next_cycle();
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_run++;
    if (bus.out_sum !== '0) begin
      n_fail++; $display("FAIL reset_out_sum: got %0h expected 0", bus.out_sum);
    end
    n_run++;
    if (bus.out_tag !== '0) begin
      n_fail++; $display("FAIL reset_out_tag: got %0h expected 0", bus.out_tag);
    end
    n_run++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_directed();
    logic [CSAWIDTH-1:0] t0 [4] = '{27'h0, 27'h7FFFFFF, 27'h3FF, 27'hFFFFF};
    logic [CSAWIDTH-1:0] t1 [4] = '{27'h0, 27'h7FFFFFF, 27'h1,   27'h0};
    logic [CSAWIDTH-1:0] t2 [4] = '{27'h0, 27'h7FFFFFF, 27'h0,   27'h1};
    logic [TAGW-1:0]     tt [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [OW-1:0]       te [4] = '{30'h0, 30'h37FFFFF9, 30'h401, 30'h100003};
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_o0 = t0[i];
      bus.in_o1 = t1[i];
      bus.in_o2 = t2[i];
      bus.in_tag = tt[i];
      next_cycle();
      drive_idle();
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
        next_cycle();
        lat++;
      end
      n_run++;
      if (lat != 4) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat);
      end
      n_run++;
      if (bus.out_sum !== te[i]) begin
        n_fail++; $display("FAIL directed_sum[%0d]: got %0h expected %0h", i, bus.out_sum, te[i]);
      end
      n_run++;
      if (bus.out_sum !== ref_sum(t0[i], t1[i], t2[i])) begin
        n_fail++; $display("FAIL directed_model[%0d]: got %0h expected %0h", i, bus.out_sum,
                           ref_sum(t0[i], t1[i], t2[i]));
      end
      n_run++;
      if (bus.out_tag !== tt[i]) begin
        n_fail++; $display("FAIL directed_tag[%0d]: got %0h expected %0h", i, bus.out_tag, tt[i]);
      end
      next_cycle();
      n_run++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL directed_single[%0d]: got out_valid %b expected 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_streaming();
    int n_out = 0;
    exp_t e;
    q.delete();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) drive_rand(TAGW'(c));
      else drive_idle();
      #1;
      if (bus.in_valid && bus.in_ready)
        q.push_back('{ref_sum(bus.in_o0, bus.in_o1, bus.in_o2), bus.in_tag});
      if (c < 8) begin
        n_run++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", c, bus.in_ready);
        end
      end
      if (bus.out_valid === 1'b1) begin
        n_run++;
        if (c != 4 + n_out) begin
          n_fail++; $display("FAIL stream_timing: output %0d in cycle %0d expected cycle %0d",
                             n_out, c, 4 + n_out);
        end
        n_run++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got output %0h with nothing expected", bus.out_sum);
        end else begin
          e = q.pop_front();
          if (bus.out_sum !== e.sum || bus.out_tag !== e.tag) begin
            n_fail++; $display("FAIL stream_data[%0d]: got %0h/%0h expected %0h/%0h", n_out,
                               bus.out_sum, bus.out_tag, e.sum, e.tag);
          end
        end
        n_out++;
      end
      next_cycle();
    end
    n_run++;
    if (n_out != 8 || q.size() != 0) begin
      n_fail++; $display("FAIL stream_count: got %0d outputs expected 8 (left %0d)", n_out, q.size());
    end
  endtask

  // mode 0: fixed 3-cycle stall once output is flowing; mode 1: random valid/ready
  task automatic run_stream(input int nbeats, input int mode, input string nm);
    int sent = 0, n_out = 0;
    logic stalled = 1'b0;
    logic [OW-1:0] hs = '0;
    logic [TAGW-1:0] ht = '0;
    exp_t e;
    q.delete();
    for (int c = 0; c < 200 && n_out < nbeats; c++) begin
      if (sent < nbeats && (mode == 0 || $urandom_range(0, 3) != 0)) drive_rand(TAGW'(sent));
      else drive_idle();
      if (mode == 0) bus.out_ready = !(c >= 6 && c <= 8);
      else bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_run++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        n_fail++; $display("FAIL %s_in_ready[%0d]: got %b expected %b", nm, c, bus.in_ready,
                           (!bus.out_valid || bus.out_ready));
      end
      if (stalled) begin
        n_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== hs || bus.out_tag !== ht) begin
          n_fail++; $display("FAIL %s_hold[%0d]: got %b/%0h/%0h expected 1/%0h/%0h", nm, c,
                             bus.out_valid, bus.out_sum, bus.out_tag, hs, ht);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      hs = bus.out_sum;
      ht = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{ref_sum(bus.in_o0, bus.in_o1, bus.in_o2), bus.in_tag});
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_run++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL %s_extra: got output %0h with nothing expected", nm, bus.out_sum);
        end else begin
          e = q.pop_front();
          if (bus.out_sum !== e.sum || bus.out_tag !== e.tag) begin
            n_fail++; $display("FAIL %s_data[%0d]: got %0h/%0h expected %0h/%0h", nm, n_out,
                               bus.out_sum, bus.out_tag, e.sum, e.tag);
          end
        end
        n_out++;
      end
      next_cycle();
    end
    drive_idle();
    bus.out_ready = 1'b1;
    repeat (8) begin
      #1;
      if (bus.out_valid) n_out++;
      next_cycle();
    end
    n_run++;
    if (n_out != nbeats || q.size() != 0) begin
      n_fail++; $display("FAIL %s_count: got %0d outputs expected %0d (left %0d)", nm, n_out,
                         nbeats, q.size());
    end
  endtask

  task automatic test_backpressure();
    run_stream(8, 0, "stall");
  endtask

  task automatic test_back_to_back();
    run_stream(24, 1, "random");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat;
    logic [OW-1:0] es;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_rand(TAGW'(8'hC0 + c));
      next_cycle();
    end
    drive_idle();
    ap_rst_n = 1'b0;
    next_cycle();
    ap_rst_n = 1'b1;
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== '0) begin
      n_fail++; $display("FAIL midreset_clear: got %b/%0h expected 0/0", bus.out_valid, bus.out_sum);
    end
    n_run++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", bus.in_ready);
    end
    repeat (8) begin
      next_cycle();
      if (bus.out_valid === 1'b1) seen++;
    end
    n_run++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midreset_ghost: got %0d stale outputs expected 0", seen);
    end
    drive_rand(8'h5A);
    es = ref_sum(bus.in_o0, bus.in_o1, bus.in_o2);
    next_cycle();
    drive_idle();
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      next_cycle();
      lat++;
    end
    n_run++;
    if (lat != 4 || bus.out_sum !== es || bus.out_tag !== 8'h5A) begin
      n_fail++; $display("FAIL midreset_fresh: got lat %0d %0h/%0h expected lat 4 %0h/5a",
                         lat, bus.out_sum, bus.out_tag, es);
    end
    next_cycle();
  endtask

  initial begin
    drive_idle();
    bus.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/csa3_cpa_pipe.md
# csa3_cpa_pipe

Pipelined carry-propagate stage directly downstream of the 5:3 bitwise compressor array in the MSM datapath. It takes the three compressed rows (weights 1, 2 and 4), reduces them to one carry-save pair with a registered full-adder layer, then resolves the carries with a segmented, staggered ripple adder, one segment per cycle. It has a single valid/ready stream on each side and carries a sideband tag through with every beat.

## Interface
Parameters:
- CSAWIDTH, 27, width of each compressor output row.
- SEGW, 10, carry-propagate segment width.
- TAGW, 8, sideband tag width.
- Derived: OW = CSAWIDTH+3; NSEG = ceil(OW/SEGW).

Ports:
- ap_clk  in  1  clock; sole clock of the block.
- ap_rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_o0  in  CSAWIDTH  compressor row, weight 1.
- in_o1  in  CSAWIDTH  compressor row, weight 2.
- in_o2  in  CSAWIDTH  compressor row, weight 4.
- in_tag  in  TAGW  sideband, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  OW  the value in_o0 + 2·in_o1 + 4·in_o2.
- out_tag  out  TAGW  tag of the same beat.

## Operation
- Alignment:
  - r0 = zero-extend(in_o0); r1 = in_o1<<1; r2 = in_o2<<2; all rows OW bits.
  - The maximum sum is 7·(2^CSAWIDTH−1) < 2^OW, so no overflow can occur.
- Stage 0 (full-adder layer), registered:
  - s = r0^r1^r2.
  - c = maj(r0,r1,r2)<<1, truncated to OW. The dropped bit is provably 0.
- Stages 1..NSEG (segmented ripple adder):
  - Stage k adds segment k−1 of s and c plus the carry registered by stage k−1.
  - Stage 1 has carry-in 0.
  - Segments not yet added move forward in staggered delay registers.
  - Completed sum segments move forward in de-skew registers.
  - The top segment may be narrower than SEGW.
  - The final carry-out is discarded; it is always 0.
- Valid bit: every stage has one; a bubble propagates like data.
- Global advance: adv = ~out_valid | out_ready.
  - When adv=1, all stages shift and stage 0 captures the input if in_valid.
  - When adv=0, every register holds its value.
- in_ready = adv. This is a combinational path from out_ready; there is no skid buffer.
- A beat transfers when in_valid & in_ready, or when out_valid & out_ready.
- Tags travel in lockstep with their data. Beat order is preserved.
- Reset (ap_rst_n=0 at an ap_clk edge):
  - All valid bits clear.
  - out_sum, out_tag and all data registers clear to 0.
  - Beats in flight are dropped, including when reset arrives mid-stream.
  - in_ready is 1 in the cycle after reset releases.

## Timing
- Latency is NSEG+1 cycles from acceptance to out_valid; 4 cycles at the defaults.
- Throughput is one beat per cycle while out_ready=1.
- Stall:
  - While out_valid=1 and out_ready=0, out_sum and out_tag stay stable and in_ready=0.
  - No beat is lost or duplicated.
  - Bubbles inside the pipe are not squeezed out during a stall.
- Simultaneous accept and emit in one cycle is legal and required for full rate.
- In-flight capacity is NSEG+1 beats.
- No combinational path from in_* to out_*.
- Critical path is one SEGW-bit ripple add plus carry-in.

## Structure
- Shared MSM package holds the constants OW and NSEG and the function that computes segment bounds, so upstream and downstream blocks agree on widths.
- One natural sub-module: csa_seg_add. It is a SEGW-bit adder with carry-in and carry-out, instantiated once per stage with the top instance narrowed.
- Stage 0 and the delay registers live inline in csa3_cpa_pipe.

## Test plan
1. Zeros: o0=o1=o2=0, tag 0x11 → after 4 cycles out_valid=1, out_sum=0, out_tag=0x11.
2. Maximum: o0=o1=o2=0x7FFFFFF → out_sum=0x37FFFFF9 (939524089).
3. Carry across segments:
   - o0=0x3FF, o1=1, o2=0 → out_sum=0x401.
   - o0=0xFFFFF, o1=0, o2=1 → out_sum=0x100003.
4. Streaming: 8 random beats, tags 0..7, out_ready=1 throughout → outputs on 8 consecutive cycles starting 4 cycles after the first, in order, each equal to the reference model o0+2·o1+4·o2.
5. Backpressure: out_ready=0 for 3 cycles while out_valid=1 → in_ready=0, out_sum and out_tag held; after release, the full sequence arrives exactly once, in order.
6. Reset mid-stream: ap_rst_n=0 for 1 cycle with 3 beats in flight → out_valid=0 and out_sum=0 on the next cycle, none of the pre-reset beats ever appear, and a fresh beat has latency 4.
